fn_desplazador_secuencial: RTL and testbench

Iterative, parametrised shifter for area-reduced builds of the RV32I execution unit. It generalises the combinational right shifter to four modes: logical left, logical right, arithmetic right and rotate right. Width is configurable, and the shift is performed PASO bit positions per clock rather than in one barrel stage. A start/busy/done handshake lets the ALU control stall while a shift is in flight.

---
 rtl/fn_desplazador_secuencial_if.sv | 30 +++
 rtl/fn_desplazador_secuencial.sv | 103 ++++++++++
 tb/tb_fn_desplazador_secuencial.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fn_desplazador_secuencial_if.sv
// Handshake/data bundle for the iterative shifter.
//   inicio  : start request, sampled on the rising clock edge
//   a       : operand
//   b       : shift amount, 0..ANCHO-1
//   modo    : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   Y       : registered result, holds the last completed result
//   ocupado : operation in flight
//   listo   : one-cycle pulse, Y carries a new result
// master drives requests (ALU control / bench); slave is the shifter.
interface fn_desplazador_secuencial_if #(
  parameter int unsigned ANCHO = 32
) ();
  logic                     inicio;
  logic [ANCHO-1:0]         a;
  logic [$clog2(ANCHO)-1:0] b;
  logic [1:0]               modo;
  logic [ANCHO-1:0]         Y;
  logic                     ocupado;
  logic                     listo;

  modport master (
    output inicio, a, b, modo,
    input  Y, ocupado, listo
  );

  modport slave (
    input  inicio, a, b, modo,
    output Y, ocupado, listo
  );
endinterface

// File: rtl/fn_desplazador_secuencial.sv
// Iterative shifter: SLL, SRL, SRA and ROR, moving at most PASO bit positions per clock.
// Ports:
//   clk    : clock, rising edge
//   nreset : asynchronous active-low reset
//   bus    : slave side of fn_desplazador_secuencial_if (inicio/a/b/modo in,
//            Y/ocupado/listo out)
// An accepted request spends ceil(b/PASO) cycles shifting plus one completion cycle in
// StDesplaza; Y is loaded and listo pulses on the completion edge.
module fn_desplazador_secuencial #(
  parameter int unsigned ANCHO = 32,
  parameter int unsigned PASO  = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  fn_desplazador_secuencial_if.slave bus
);
  localparam int unsigned BW = $clog2(ANCHO);
  // Only selected when PASO <= restante < ANCHO, so PASO < ANCHO and it fits in BW bits.
  localparam logic [BW-1:0] PasoMax = BW'(PASO);

  typedef enum logic [0:0] {StReposo, StDesplaza} estado_t;

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] acc_q, acc_d;
  logic [BW-1:0]    restante_q, restante_d;
  logic [1:0]       modo_q, modo_d;
  logic [ANCHO-1:0] y_q, y_d;
  logic             listo_q, listo_d;

  logic [BW-1:0]    paso;
  logic [BW-1:0]    paso_inv;
  logic [ANCHO-1:0] acc_sh;

  // One shift step of min(restante, PASO) positions in the latched mode.
  always_comb begin
    paso = PasoMax;
    if (32'(restante_q) < PASO) begin
      paso = restante_q;
    end
    // ANCHO - paso modulo ANCHO; ANCHO is a power of two so two's complement does it.
    paso_inv = ~paso + BW'(1);
    unique case (modo_q)
      2'b00:   acc_sh = acc_q << paso;
      2'b01:   acc_sh = acc_q >> paso;
      2'b10:   acc_sh = $unsigned($signed(acc_q) >>> paso);
      default: acc_sh = (acc_q >> paso) | (acc_q << paso_inv);
    endcase
  end

  always_comb begin
    estado_d   = estado_q;
    acc_d      = acc_q;
    restante_d = restante_q;
    modo_d     = modo_q;
    y_d        = y_q;
    listo_d    = 1'b0;
    unique case (estado_q)
      StReposo: begin
        if (bus.inicio) begin
          acc_d      = bus.a;
          restante_d = bus.b;
          modo_d     = bus.modo;
          estado_d   = StDesplaza;
        end
      end
      StDesplaza: begin
        // inicio is deliberately not looked at here: requests in flight are dropped.
        if (restante_q != '0) begin
          acc_d      = acc_sh;
          restante_d = restante_q - paso;
        end else begin
          y_d      = acc_q;
          listo_d  = 1'b1;
          estado_d = StReposo;
        end
      end
      default: estado_d = StReposo;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      estado_q   <= StReposo;
      acc_q      <= '0;
      restante_q <= '0;
      modo_q     <= '0;
      y_q        <= '0;
      listo_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      acc_q      <= acc_d;
      restante_q <= restante_d;
      modo_q     <= modo_d;
      y_q        <= y_d;
      listo_q    <= listo_d;
    end
  end

  assign bus.Y       = y_q;
  assign bus.ocupado = (estado_q == StDesplaza);
  assign bus.listo   = listo_q;

endmodule

// File: tb/tb_fn_desplazador_secuencial.sv
// Bench for fn_desplazador_secuencial: three instances (PASO = 1, 4, 32, ANCHO = 32) share
// one stimulus stream. Directed scenarios are checked on the PASO = 4 instance; the sweep
// checks all three against a behavioural shift model and the expected latency.
module tb_fn_desplazador_secuencial;
  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        nreset;
  logic        inicio;
  logic [31:0] a_v;
  logic [4:0]  b_v;
  logic [1:0]  modo_v;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned pv [3] = '{1, 4, 32};

  always #5 clk = ~clk;

  fn_desplazador_secuencial_if #(.ANCHO(32)) bus1 ();
  fn_desplazador_secuencial_if #(.ANCHO(32)) bus4 ();
  fn_desplazador_secuencial_if #(.ANCHO(32)) bus32 ();

  fn_desplazador_secuencial #(.ANCHO(32), .PASO(1)) dut1 (
    .clk(clk), .nreset(nreset), .bus(bus1.slave));
  fn_desplazador_secuencial #(.ANCHO(32), .PASO(4)) dut4 (
    .clk(clk), .nreset(nreset), .bus(bus4.slave));
  fn_desplazador_secuencial #(.ANCHO(32), .PASO(32)) dut32 (
    .clk(clk), .nreset(nreset), .bus(bus32.slave));

  assign bus1.inicio  = inicio;
  assign bus1.a       = a_v;
  assign bus1.b       = b_v;
  assign bus1.modo    = modo_v;
  assign bus4.inicio  = inicio;
  assign bus4.a       = a_v;
  assign bus4.b       = b_v;
  assign bus4.modo    = modo_v;
  assign bus32.inicio = inicio;
  assign bus32.a      = a_v;
  assign bus32.b      = b_v;
  assign bus32.modo   = modo_v;

  logic [31:0] y_all [3];
  logic [2:0]  listo_all;
  logic [2:0]  ocup_all;
  assign y_all[0] = bus1.Y;
  assign y_all[1] = bus4.Y;
  assign y_all[2] = bus32.Y;
  assign listo_all = {bus32.listo, bus4.listo, bus1.listo};
  assign ocup_all  = {bus32.ocupado, bus4.ocupado, bus1.ocupado};

  int          lat_obs [3];
  logic [31:0] y_obs [3];
  bit          done_obs [3];
  int          ocup4;
  bit          y4_moved;

  function automatic logic [31:0] ref_shift(input logic [31:0] av, input int bv,
                                            input logic [1:0] mv);
    logic [63:0] dbl;
    case (mv)
      2'b00:   dbl = {32'h0, av} << bv;
      2'b01:   dbl = {32'h0, av} >> bv;
      2'b10:   dbl = {{32{av[31]}}, av} >> bv;
      default: dbl = {av, av} >> bv;
    endcase
    return dbl[31:0];
  endfunction

  // Presents a request for exactly one edge; returns at the negedge after the accept edge.
  task automatic launch(input logic [31:0] av, input int bv, input logic [1:0] mv);
    @(negedge clk);
    inicio = 1'b1;
    a_v    = av;
    b_v    = 5'(bv);
    modo_v = mv;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    a_v    = $urandom;
    b_v    = 5'($urandom);
    modo_v = 2'($urandom);
  endtask

  // Samples each negedge (e = edges after accept) until every instance has pulsed listo.
  task automatic wait_done(input string name);
    logic [31:0] y4_start;
    for (int i = 0; i < 3; i++) begin
      done_obs[i] = 1'b0;
      lat_obs[i]  = -1;
      y_obs[i]    = 32'h0;
    end
    ocup4    = 0;
    y4_moved = 1'b0;
    y4_start = y_all[1];
    for (int e = 0; e <= BUDGET; e++) begin
      if (e > 0) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!done_obs[i] && listo_all[i]) begin
          done_obs[i] = 1'b1;
          lat_obs[i]  = e;
          y_obs[i]    = y_all[i];
        end
      end
      if (!done_obs[1]) begin
        if (ocup_all[1]) ocup4++;
        if (y_all[1] !== y4_start) y4_moved = 1'b1;
      end
      if (done_obs[0] && done_obs[1] && done_obs[2]) break;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (!done_obs[i]) begin
        n_errors++;
        $display("FAIL %s timeout PASO=%0d: no listo within %0d edges", name, pv[i], BUDGET);
      end
    end
  endtask

  task automatic test_reset();
    inicio = 1'b0;
    a_v    = '0;
    b_v    = '0;
    modo_v = '0;
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({y_all[i], ocup_all[i], listo_all[i]} !== 34'h0) begin
        n_errors++;
        $display("FAIL reset PASO=%0d: Y=%h ocupado=%b listo=%b required 0/0/0",
                 pv[i], y_all[i], ocup_all[i], listo_all[i]);
      end
    end
    nreset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] da [7] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000001,
                            32'h00000001, 32'h12345678, 32'h12345678};
    int          db [7] = '{31, 31, 30, 0, 31, 8, 4};
    logic [1:0]  dm [7] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b11, 2'b11};
    logic [31:0] dy [7] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001,
                            32'h80000000, 32'h78123456, 32'h81234567};
    int          dl [7] = '{9, 9, 9, 1, 9, 3, 2};
    for (int t = 0; t < 7; t++) begin
      launch(da[t], db[t], dm[t]);
      wait_done("directed");
      n_checks++;
      if (y_obs[1] !== dy[t]) begin
        n_errors++;
        $display("FAIL directed%0d Y: got %h required %h", t, y_obs[1], dy[t]);
      end
      n_checks++;
      if (lat_obs[1] != dl[t]) begin
        n_errors++;
        $display("FAIL directed%0d latency: got %0d required %0d", t, lat_obs[1], dl[t]);
      end
      n_checks++;
      if (ocup4 != dl[t]) begin
        n_errors++;
        $display("FAIL directed%0d ocupado cycles: got %0d required %0d", t, ocup4, dl[t]);
      end
      n_checks++;
      if (y4_moved !== 1'b0) begin
        n_errors++;
        $display("FAIL directed%0d Y stable while busy: got moved=1 required 0", t);
      end
    end
  endtask

  task automatic test_back_to_back();
    launch(32'hF0000000, 4, 2'b01);
    inicio = 1'b1;
    a_v    = 32'hFFFFFFFF;
    b_v    = 5'd0;
    modo_v = 2'b00;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({listo_all[1], y_all[1]} !== {1'b1, 32'h0F000000}) begin
      n_errors++;
      $display("FAIL b2b op1: listo=%b Y=%h required 1 0f000000", listo_all[1], y_all[1]);
    end
    inicio = 1'b1;
    a_v    = 32'h00000001;
    b_v    = 5'd1;
    modo_v = 2'b00;
    @(negedge clk);
    inicio = 1'b0;
    a_v    = $urandom;
    n_checks++;
    if ({listo_all[1], ocup_all[1], y_all[1]} !== {2'b01, 32'h0F000000}) begin
      n_errors++;
      $display("FAIL b2b accept: listo=%b ocupado=%b Y=%h required 0 1 0f000000",
               listo_all[1], ocup_all[1], y_all[1]);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({listo_all[1], y_all[1]} !== {1'b1, 32'h00000002}) begin
      n_errors++;
      $display("FAIL b2b op2: listo=%b Y=%h required 1 00000002", listo_all[1], y_all[1]);
    end
    repeat (BUDGET) @(negedge clk);
  endtask

  task automatic test_abort();
    launch(32'h8badf00d, 20, 2'b10);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    n_checks++;
    if ({y_all[1], ocup_all[1], listo_all[1]} !== 34'h0) begin
      n_errors++;
      $display("FAIL abort: Y=%h ocupado=%b listo=%b required 0/0/0",
               y_all[1], ocup_all[1], listo_all[1]);
    end
    @(negedge clk);
    n_checks++;
    if (listo_all !== 3'b000) begin
      n_errors++;
      $display("FAIL abort pulse: listo=%b required 000", listo_all);
    end
    nreset = 1'b1;
    inicio = 1'b1;
    a_v    = 32'h80000000;
    b_v    = 5'd16;
    modo_v = 2'b01;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    wait_done("abort");
    n_checks++;
    if (y_obs[1] !== 32'h00008000 || lat_obs[1] != 5) begin
      n_errors++;
      $display("FAIL after abort: Y=%h lat=%0d required 00008000 5", y_obs[1], lat_obs[1]);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] av;
    logic [31:0] exp_y;
    int          exp_l;
    for (int m = 0; m < 4; m++) begin
      for (int bv = 0; bv < 32; bv++) begin
        av = $urandom;
        launch(av, bv, 2'(m));
        wait_done("sweep");
        exp_y = ref_shift(av, bv, 2'(m));
        for (int i = 0; i < 3; i++) begin
          exp_l = (bv + int'(pv[i]) - 1) / int'(pv[i]) + 1;
          n_checks++;
          if (y_obs[i] !== exp_y) begin
            n_errors++;
            $display("FAIL sweep Y PASO=%0d modo=%0d a=%h b=%0d: got %h required %h",
                     pv[i], m, av, bv, y_obs[i], exp_y);
          end
          n_checks++;
          if (lat_obs[i] != exp_l) begin
            n_errors++;
            $display("FAIL sweep latency PASO=%0d modo=%0d b=%0d: got %0d required %0d",
                     pv[i], m, bv, lat_obs[i], exp_l);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
